// File: rtl/encoder.sv
// -----------------------------------------------------------------------------
// encoder
//
// Registered N-to-log2(N) binary priority encoder. It converts the request
// vector I into the binary index of its highest-order set bit, plus a valid
// flag that separates "bit 0 set" from "nothing set". All outputs are
// registered, so there is no combinational path from I to any output.
//
// Parameters:
//   N  - request vector width, 2..256 (default 4)
//   W  - index width, fixed at $clog2(N); it cannot be overridden
//
// Ports:
//   CLK  in  1  clock; all state updates on the rising edge
//   RST  in  1  synchronous active-high reset; clears Y, V and ERR; beats EN
//   EN   in  1  capture enable; when low, the outputs hold
//   I    in  N  request vector; bit N-1 has the highest priority
//   Y    out W  registered index of the highest set bit of I (0 when I == 0)
//   V    out 1  registered valid; 1 when any bit of I was set at capture
//   ERR  out 1  registered multi-hot flag (present only with ENCODER_ERR_EN)
//
// Build option:
//   ENCODER_ERR_EN - when defined, adds the ERR port and its register.
//                    ERR is 1 when two or more bits of I were set at capture.
//
// Latency is one cycle: the I and EN sampled at edge t are visible after edge t.
// -----------------------------------------------------------------------------
module encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [N-1:0] I,
  output logic [W-1:0] Y,
`ifdef ENCODER_ERR_EN
  output logic         V,
  output logic         ERR
`else
  output logic         V
`endif
);

  logic [W-1:0] enc_y;
  logic         enc_v;

  // Ascending scan: a later (higher) set bit overwrites an earlier one, so
  // the last write wins and lands on the highest-order set bit. Only indices
  // 0..N-1 are ever written, so unused codes never appear when N is not a
  // power of two.
  always_comb begin
    enc_y = '0;
    for (int k = 0; k < N; k++) begin
      if (I[k]) enc_y = W'(k);
    end
    enc_v = |I;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Y <= '0;
      V <= 1'b0;
    end else if (EN) begin
      Y <= enc_y;
      V <= enc_v;
    end
  end

`ifdef ENCODER_ERR_EN
  logic enc_err;

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set; this avoids building a full popcount.
  always_comb begin
    enc_err = |(I & (I - N'(1)));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (EN) begin
      ERR <= enc_err;
    end
  end
`endif

endmodule

// File: tb/tb_encoder.sv
// -----------------------------------------------------------------------------
// tb_encoder
//
// Directed bench for encoder. It drives the default 4-input instance and a
// 5-input instance from the same clock and reset. Expected values are written
// out by hand next to each step. Inputs change 1 ns after the rising edge, and
// outputs are sampled at that same moment, well away from the edge.
// -----------------------------------------------------------------------------
module tb_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [3:0] i4;
  logic [1:0] y4;
  logic       v4;
  logic       err4;

  logic       en5;
  logic [4:0] i5;
  logic [2:0] y5;
  logic       v5;
  logic       err5;

  // ---------------- DUTs ----------------
  encoder #(.N(4)) dut4 (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .I   (i4),
    .Y   (y4),
`ifdef ENCODER_ERR_EN
    .V   (v4),
    .ERR (err4)
`else
    .V   (v4)
`endif
  );

  encoder #(.N(5)) dut5 (
    .CLK (clk),
    .RST (rst),
    .EN  (en5),
    .I   (i5),
    .Y   (y5),
`ifdef ENCODER_ERR_EN
    .V   (v5),
    .ERR (err5)
`else
    .V   (v5)
`endif
  );

`ifndef ENCODER_ERR_EN
  assign err4 = 1'b0;
  assign err5 = 1'b0;
`endif

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Checks Y/V (and ERR when the port exists) of the 4-input instance.
  task automatic check4(input string tag, input logic [1:0] ey, input logic ev, input logic eerr);
    check({tag, ".y"}, {6'd0, y4}, {6'd0, ey});
    check({tag, ".v"}, {7'd0, v4}, {7'd0, ev});
`ifdef ENCODER_ERR_EN
    check({tag, ".err"}, {7'd0, err4}, {7'd0, eerr});
`else
    if (eerr !== eerr) n_checks = n_checks; // keep eerr referenced
`endif
  endtask

  task automatic check5(input string tag, input logic [2:0] ey, input logic ev, input logic eerr);
    check({tag, ".y5"}, {5'd0, y5}, {5'd0, ey});
    check({tag, ".v5"}, {7'd0, v5}, {7'd0, ev});
`ifdef ENCODER_ERR_EN
    check({tag, ".err5"}, {7'd0, err5}, {7'd0, eerr});
`else
    if (eerr !== eerr) n_checks = n_checks;
`endif
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] sweep_i [5];
  logic [1:0] sweep_y [5];

  initial begin
    sweep_i[0] = 4'b1000; sweep_y[0] = 2'b11;
    sweep_i[1] = 4'b0100; sweep_y[1] = 2'b10;
    sweep_i[2] = 4'b0010; sweep_y[2] = 2'b01;
    sweep_i[3] = 4'b0001; sweep_y[3] = 2'b00;
    sweep_i[4] = 4'b0100; sweep_y[4] = 2'b10;

    rst = 1'b1;
    en  = 1'b1;
    i4  = 4'b1000;
    en5 = 1'b1;
    i5  = 5'b10000;

    // Reset wins over EN while I is non-zero.
    tick();
    check4("rst_edge1", 2'b00, 1'b0, 1'b0);
    check5("rst_edge1", 3'b000, 1'b0, 1'b0);
    tick();
    check4("rst_edge2", 2'b00, 1'b0, 1'b0);
    check5("rst_edge2", 3'b000, 1'b0, 1'b0);

    // First capture after release.
    rst = 1'b0;
    tick();
    check4("rst_release", 2'b11, 1'b1, 1'b0);
    check5("n5_top", 3'b100, 1'b1, 1'b0);

    // One-hot sweep.
    for (int s = 0; s < 5; s++) begin
      i4 = sweep_i[s];
      tick();
      check4($sformatf("sweep%0d", s), sweep_y[s], 1'b1, 1'b0);
    end

    // Zero input.
    i4 = 4'b0000;
    i5 = 5'b00000;
    tick();
    check4("zero", 2'b00, 1'b0, 1'b0);
    check5("n5_zero", 3'b000, 1'b0, 1'b0);

    // Priority / multi-hot.
    i4 = 4'b0111;
    i5 = 5'b00111;
    tick();
    check4("multi_0111", 2'b10, 1'b1, 1'b1);
    check5("n5_00111", 3'b010, 1'b1, 1'b1);
    i4 = 4'b1111;
    i5 = 5'b10001;
    tick();
    check4("multi_1111", 2'b11, 1'b1, 1'b1);
    check5("n5_10001", 3'b100, 1'b1, 1'b1);
    i4 = 4'b0001;
    i5 = 5'b01000;
    tick();
    check4("onehot_after_multi", 2'b00, 1'b1, 1'b0);
    check5("n5_01000", 3'b011, 1'b1, 1'b0);

    // Hold: EN low freezes the outputs while I changes.
    i4 = 4'b0010;
    tick();
    check4("hold_capture", 2'b01, 1'b1, 1'b0);
    en  = 1'b0;
    en5 = 1'b0;
    i4  = 4'b1000;
    i5  = 5'b00001;
    for (int h = 0; h < 3; h++) begin
      tick();
      check4($sformatf("hold%0d", h), 2'b01, 1'b1, 1'b0);
      check5($sformatf("n5_hold%0d", h), 3'b011, 1'b1, 1'b0);
    end
    en  = 1'b1;
    en5 = 1'b1;
    tick();
    check4("hold_release", 2'b11, 1'b1, 1'b0);
    check5("n5_hold_release", 3'b000, 1'b1, 1'b0);

    // Mid-stream reset with multi-hot input and EN high.
    i4  = 4'b1100;
    rst = 1'b1;
    tick();
    check4("mid_rst", 2'b00, 1'b0, 1'b0);
    check5("n5_mid_rst", 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check4("after_mid_rst", 2'b11, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder.md
# encoder

Registered N-to-log2(N) binary priority encoder. Converts an N-bit request vector into the binary index of its highest-order asserted bit, with a valid flag for the all-zero case. Used wherever a one-hot or multi-hot select vector must be turned into a compact index, for example arbiter grant-to-index conversion or interrupt-source numbering. Default configuration is the 4-to-2 encoder.

## Interface
- N, default 4: input vector width; legal range 2..256.
- W, derived localparam, equal to clog2(N): index width (2 for N=4). It is not overridable.
- CLK, input, 1: the single clock; all state updates on the rising edge.
- RST, input, 1: reset; it is synchronous and active-high.
- EN, input, 1: capture enable; when low, outputs hold.
- I, input, N: request vector; bit N-1 has the highest priority.
- Y, output, W: registered binary index of the highest set bit of I.
- V, output, 1: registered valid; 1 when any bit of I was set at capture.
- ERR, output, 1: registered multi-hot flag; 1 when more than one bit of I was set at capture. This port is present only with ENCODER_ERR_EN.

## Operation
- Combinational index = largest k with I[k]=1.
- If I is all zero, the index is 0 and valid is 0.
- The encoding is a pure priority function; lower-order set bits are ignored for Y.
- N=4 mapping:
  - I=1000 gives Y=11, V=1.
  - I=0100 gives Y=10, V=1.
  - I=0010 gives Y=01, V=1.
  - I=0001 gives Y=00, V=1.
  - I=0000 gives Y=00, V=0.
- Multi-hot example: I=0110 gives Y=10, V=1 (and ERR=1 when ENCODER_ERR_EN is defined).
- For N not a power of two, unused index codes are never produced.
- No state machine. Only the output registers Y, V and ERR exist.

## Timing
- Reset: on a rising CLK edge with RST=1, the outputs become Y=0, V=0, ERR=0. Reset overrides EN.
- Latency: 1 cycle. The values of I and EN sampled at edge t appear on Y, V and ERR after edge t.
- EN=0 at an edge: Y, V and ERR keep their previous values. Changes on I are ignored.
- EN=1 at an edge: Y, V and ERR are loaded from the combinational encode of I.
- RST asserted mid-stream: the outputs clear at that edge. The first valid capture is at the first edge with RST=0 and EN=1.
- I must be stable within setup/hold of CLK. There is no internal synchronizer, and no combinational path from I to any output.
- Throughput: one new encode per cycle while EN=1.

## Configuration
- ENCODER_ERR_EN defined:
  - The ERR port exists.
  - ERR is registered alongside Y and V, with the same enable and reset.
  - ERR=1 when the popcount of I is 2 or more. ERR=0 when I is zero or one-hot.
- ENCODER_ERR_EN undefined:
  - The ERR port and its logic are absent.
  - Y and V behave identically to the defined case.

## Test plan
- Reset: assert RST with I=1000 and EN=1 for 2 edges. Y=00 and V=0 (ERR=0) must hold throughout. Release RST: after the next edge, Y=11 and V=1.
- One-hot sweep with EN=1, one edge apart, in the order I=1000, 0100, 0010, 0001, 0100. Y must follow one cycle later as 11, 10, 01, 00, 10, with V=1 each time and ERR=0.
- Zero input: I=0000 with EN=1 gives Y=00, V=0 and ERR=0 after one edge.
- Priority and multi-hot: I=0111 gives Y=10 and V=1. I=1111 gives Y=11. With ENCODER_ERR_EN, ERR=1 for both. Following with I=0001 gives ERR=0.
- Hold: capture I=0010, giving Y=01. Then set EN=0 and drive I=1000 for 3 edges. Y must stay 01 and V must stay 1. Raising EN gives Y=11 after one edge.
- Parameter: with N=5, W is 3. I=10000 gives Y=100. I=00000 gives V=0.
